vga_prefetch_buffer: RTL and testbench

- Parametrised circular prefetch buffer between the VGA timing generator and main memory.
- Holds upcoming framebuffer pixels, one byte per pixel, and refills them with burst reads through the MIG-style read port.
- Compared with the single-line buffer, it adds:
  - configurable depth and burst length;
  - asynchronous reset;
  - double-buffered frame base selection;
  - a resync input that restarts the stream at any pixel;
  - underflow and coordinate-mismatch reporting.

---
 rtl/vga_prefetch_buffer_if.sv | 22 ++
 rtl/vga_prefetch_buffer.sv | 182 ++++++++++++++++++
 tb/tb_vga_prefetch_buffer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_prefetch_buffer_if.sv
// Memory-side bus of the VGA prefetch buffer: MIG-style read command port and read-data FIFO.
// The buffer is the master (issues commands, pops data); the memory controller is the slave.
interface vga_prefetch_buffer_if;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_full;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;
  logic        mem_rd_empty;

  modport master (
    output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en,
    input  mem_cmd_full, mem_rd_data, mem_rd_empty
  );

  modport slave (
    input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en,
    output mem_cmd_full, mem_rd_data, mem_rd_empty
  );
endinterface

// File: rtl/vga_prefetch_buffer.sv
// Circular prefetch buffer feeding the VGA timing generator with framebuffer bytes,
// refilled by burst reads; supports resync, double-buffered frame base and error reporting.
//
// state   | meaning
// S_IDLE  | waiting for room for one more burst
// S_CMD   | strobing a read command once the command FIFO has room
// S_READ  | popping and storing the words of the outstanding burst
// S_DRAIN | discarding words left in flight by a resync
module vga_prefetch_buffer #(
  parameter int          BUF_DEPTH   = 256,
  parameter int          BURST_WORDS = 16,
  parameter int          X_BITS      = 8,
  parameter int          Y_BITS      = 8,
  parameter int          SCREEN_H    = 192,
  parameter logic [29:0] FB0_BASE    = 30'h0001_0000,
  parameter logic [29:0] FB1_BASE    = 30'h0002_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [X_BITS-1:0]     x_coord,
  input  logic [Y_BITS-1:0]     y_coord,
  input  logic                  invalidate,
  input  logic                  resync,
  input  logic                  frame_sel,
  output logic                  empty,
  output logic [7:0]            rgb,
  output logic [15:0]           underflow_count,
  output logic                  sync_err,
  vga_prefetch_buffer_if.master mem
);

  localparam int PTR_W       = X_BITS + Y_BITS;
  localparam int PIX         = (2 ** X_BITS) * SCREEN_H;
  localparam int AW          = $clog2(BUF_DEPTH);
  localparam int CNT_W       = AW + 1;
  localparam int BURST_BYTES = BURST_WORDS * 4;

  localparam logic [PTR_W-1:0] PIX_LAST   = PTR_W'(PIX - 1);
  localparam logic [PTR_W-1:0] FETCH_LAST = PTR_W'(PIX - BURST_BYTES);
  localparam logic [PTR_W-1:0] WR_LAST    = PTR_W'(PIX - 4);
  localparam logic [CNT_W+1:0] SPACE_MAX  = (CNT_W + 2)'(BUF_DEPTH - BURST_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMD   = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_fetch_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_valid_len;
  logic [CNT_W-1:0] r_inflight;
  logic [29:0]      r_active_base;
  logic [7:0]       r_rgb;
  logic [15:0]      r_underflow;
  logic             r_sync_err;
  logic [31:0]      r_buf [BUF_DEPTH/4];

  logic [PTR_W-1:0] w_flat;
  logic [PTR_W-1:0] w_resync_ptr;
  logic [CNT_W+1:0] w_reserved;
  logic             w_space_ok;
  logic             w_empty;
  logic             w_consume;
  logic             w_underflow;
  logic             w_cmd_fire;
  logic             w_pop;
  logic             w_wr;
  logic [31:0]      w_head_word;

  assign w_flat       = {y_coord, x_coord};
  assign w_resync_ptr = {w_flat[PTR_W-1:2], 2'b00};

  // Words already commanded count against free space so a burst can never overrun the head.
  assign w_reserved = (CNT_W + 2)'(r_valid_len) + {r_inflight, 2'b00};
  assign w_space_ok = (w_reserved <= SPACE_MAX);

  assign w_empty     = (r_valid_len == '0);
  assign w_consume   = invalidate && !w_empty && !resync;
  assign w_underflow = invalidate && w_empty && !resync;
  assign w_cmd_fire  = (r_state == S_CMD) && !mem.mem_cmd_full && !resync;
  assign w_pop       = ((r_state == S_READ) || (r_state == S_DRAIN)) && !mem.mem_rd_empty
                       && !resync && (r_inflight != '0);
  assign w_wr        = w_pop && (r_state == S_READ);

  assign mem.mem_cmd_en        = w_cmd_fire;
  assign mem.mem_cmd_instr     = 3'b001;
  assign mem.mem_cmd_bl        = 6'(BURST_WORDS - 1);
  assign mem.mem_cmd_byte_addr = r_active_base + 30'(r_fetch_ptr);
  assign mem.mem_rd_en         = w_pop;

  assign empty           = w_empty;
  assign rgb             = r_rgb;
  assign underflow_count = r_underflow;
  assign sync_err        = r_sync_err;

  assign w_head_word = r_buf[r_head[AW-1:2]];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[r_wr_ptr[AW-1:2]] <= mem.mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= 8'h00;
    end else begin
      r_rgb <= w_head_word[{r_head[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_head        <= '0;
      r_fetch_ptr   <= '0;
      r_wr_ptr      <= '0;
      r_valid_len   <= '0;
      r_inflight    <= '0;
      r_active_base <= FB0_BASE;
      r_underflow   <= 16'h0000;
      r_sync_err    <= 1'b0;
    end else if (resync) begin
      r_head      <= w_resync_ptr;
      r_fetch_ptr <= w_resync_ptr;
      r_wr_ptr    <= w_resync_ptr;
      r_valid_len <= '0;
      r_sync_err  <= 1'b0;
      r_state     <= (r_inflight != '0) ? S_DRAIN : S_IDLE;
    end else begin
      if (w_consume) begin
        r_head <= (r_head == PIX_LAST) ? '0 : r_head + 1'b1;
        if (w_flat != r_head) begin
          r_sync_err <= 1'b1;
        end
      end

      if (w_underflow && (r_underflow != 16'hFFFF)) begin
        r_underflow <= r_underflow + 1'b1;
      end

      r_valid_len <= r_valid_len + (w_wr ? CNT_W'(4) : '0) - (w_consume ? CNT_W'(1) : '0);
      r_inflight  <= r_inflight + (w_cmd_fire ? CNT_W'(BURST_WORDS) : '0) - (w_pop ? CNT_W'(1) : '0);

      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == WR_LAST) ? '0 : r_wr_ptr + PTR_W'(4);
      end

      // The frame base only switches when fetching rolls over to the first pixel.
      if (w_cmd_fire) begin
        if (r_fetch_ptr == FETCH_LAST) begin
          r_fetch_ptr   <= '0;
          r_active_base <= frame_sel ? FB1_BASE : FB0_BASE;
        end else begin
          r_fetch_ptr <= r_fetch_ptr + PTR_W'(BURST_BYTES);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_space_ok) begin
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_cmd_fire) begin
            r_state <= S_READ;
          end
        end
        S_READ, S_DRAIN: begin
          if (w_pop && (r_inflight == CNT_W'(1))) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_prefetch_buffer.sv
// Directed bench for vga_prefetch_buffer with a 3-cycle-latency memory model
// that returns byte = address[7:0].
module tb_vga_prefetch_buffer;

  localparam int PIX = 49152;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  x_coord;
  logic [7:0]  y_coord;
  logic        invalidate;
  logic        resync;
  logic        frame_sel;
  logic        empty;
  logic [7:0]  rgb;
  logic [15:0] underflow_count;
  logic        sync_err;

  vga_prefetch_buffer_if mem_if ();

  vga_prefetch_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .x_coord         (x_coord),
    .y_coord         (y_coord),
    .invalidate      (invalidate),
    .resync          (resync),
    .frame_sel       (frame_sel),
    .empty           (empty),
    .rgb             (rgb),
    .underflow_count (underflow_count),
    .sync_err        (sync_err),
    .mem             (mem_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_head = 0;
  int pop_cnt  = 0;
  int pop_allow = -1;
  bit stall    = 1'b0;

  logic [29:0] cmd_log [$];
  logic [29:0] q_addr [$];
  int          q_rdy [$];
  bit          cmd_fire_s;
  bit          rd_fire_s;
  logic [29:0] cmd_addr_s;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Handshakes sampled mid-cycle; FIFO state updated just after the edge that consumed them.
  always @(negedge clk) begin
    cmd_fire_s = mem_if.mem_cmd_en;
    rd_fire_s  = mem_if.mem_rd_en;
    cmd_addr_s = mem_if.mem_cmd_byte_addr;
    if (cmd_fire_s) cmd_log.push_back(cmd_addr_s);
    if (rd_fire_s) pop_cnt++;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rd_fire_s && q_addr.size() != 0) begin
      void'(q_addr.pop_front());
      void'(q_rdy.pop_front());
      if (pop_allow > 0) pop_allow--;
    end
    if (cmd_fire_s) begin
      for (int i = 0; i < 16; i++) begin
        q_addr.push_back(cmd_addr_s + 30'(4 * i));
        q_rdy.push_back(cyc + 3);
      end
    end
    rd_fire_s  = 1'b0;
    cmd_fire_s = 1'b0;
    mem_if.mem_rd_empty = stall || (q_addr.size() == 0) || (q_rdy[0] > cyc) || (pop_allow == 0);
    mem_if.mem_rd_data  = (q_addr.size() != 0) ? word_of(q_addr[0]) : 32'h0;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stream(input int n, input string tag);
    int got = 0;
    int guard = 0;
    bit drove;
    while (got < n && guard < 4 * n + 2000) begin
      drove = !empty;
      invalidate = drove;
      {y_coord, x_coord} = 16'(exp_head);
      tick(1);
      guard++;
      if (drove) begin
        n_checks++;
        if (rgb !== exp_head[7:0]) begin
          n_fail++;
          $display("FAIL %s rgb pix=%0d got=%h exp=%h", tag, exp_head, rgb, exp_head[7:0]);
        end
        exp_head = (exp_head == PIX - 1) ? 0 : exp_head + 1;
        got++;
      end
    end
    invalidate = 1'b0;
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s stream_timeout consumed=%0d required=%0d", tag, got, n);
    end
  endtask

  task automatic do_resync(input logic [7:0] x, input logic [7:0] y);
    invalidate = 1'b0;
    resync     = 1'b1;
    x_coord    = x;
    y_coord    = y;
    tick(1);
    resync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    invalidate = 1'b0;
    resync = 1'b0;
    frame_sel = 1'b0;
    x_coord = 8'h00;
    y_coord = 8'h00;
    mem_if.mem_cmd_full = 1'b1;
    tick(3);
    n_checks += 9;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got=%h exp=00", rgb); end
    if (underflow_count !== 16'h0) begin n_fail++; $display("FAIL reset_underflow got=%0d exp=0", underflow_count); end
    if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
    if (mem_if.mem_cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_en got=%b exp=0", mem_if.mem_cmd_en); end
    if (mem_if.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", mem_if.mem_rd_en); end
    if (mem_if.mem_cmd_instr !== 3'b001) begin n_fail++; $display("FAIL cmd_instr got=%b exp=001", mem_if.mem_cmd_instr); end
    if (mem_if.mem_cmd_bl !== 6'd15) begin n_fail++; $display("FAIL cmd_bl got=%0d exp=15", mem_if.mem_cmd_bl); end
    if (mem_if.mem_cmd_byte_addr !== 30'h10000) begin n_fail++; $display("FAIL reset_addr got=%h exp=10000", mem_if.mem_cmd_byte_addr); end
    rst_n = 1'b1;
    tick(5);
    n_checks++;
    if (cmd_log.size() != 0) begin n_fail++; $display("FAIL cmd_while_full count=%0d exp=0", cmd_log.size()); end
    mem_if.mem_cmd_full = 1'b0;
  endtask

  task automatic test_initial_fill();
    logic [29:0] exp_addr;
    tick(300);
    n_checks += 3;
    if (cmd_log.size() != 4) begin n_fail++; $display("FAIL fill_cmd_count got=%0d exp=4", cmd_log.size()); end
    if (pop_cnt != 64) begin n_fail++; $display("FAIL fill_pop_count got=%0d exp=64", pop_cnt); end
    if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty got=%b exp=0", empty); end
    for (int i = 0; i < 4 && i < cmd_log.size(); i++) begin
      exp_addr = 30'h10000 + 30'(64 * i);
      n_checks++;
      if (cmd_log[i] !== exp_addr) begin n_fail++; $display("FAIL fill_addr%0d got=%h exp=%h", i, cmd_log[i], exp_addr); end
    end
  endtask

  task automatic test_full_frame();
    exp_head = 0;
    stream(PIX, "frame");
    n_checks += 3;
    if (underflow_count !== 16'h0) begin n_fail++; $display("FAIL frame_underflow got=%0d exp=0", underflow_count); end
    if (sync_err !== 1'b0) begin n_fail++; $display("FAIL frame_sync_err got=%b exp=0", sync_err); end
    if (cmd_log.size() < 769) begin
      n_fail++;
      $display("FAIL frame_cmd_count got=%0d exp>=769", cmd_log.size());
    end else begin
      n_checks++;
      if (cmd_log[767] !== 30'h1BFC0) begin n_fail++; $display("FAIL frame_last_addr got=%h exp=1bfc0", cmd_log[767]); end
      if (cmd_log[768] !== 30'h10000) begin n_fail++; $display("FAIL frame_wrap_addr got=%h exp=10000", cmd_log[768]); end
    end
  endtask

  task automatic test_stall();
    tick(100);
    stall = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 255) begin
        n_checks++;
        if (empty !== 1'b0) begin n_fail++; $display("FAIL stall_empty_early got=%b exp=0 at=%0d", empty, i); end
      end
      if (i == 256 || i == 299) begin
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL stall_empty_late got=%b exp=1 at=%0d", empty, i); end
      end
      invalidate = 1'b1;
      {y_coord, x_coord} = 16'(exp_head);
      tick(1);
      if (i < 256) exp_head = exp_head + 1;
    end
    invalidate = 1'b0;
    n_checks++;
    if (underflow_count !== 16'd44) begin n_fail++; $display("FAIL stall_underflow got=%0d exp=44", underflow_count); end
    stall = 1'b0;
    stream(300, "after_stall");
    n_checks++;
    if (sync_err !== 1'b0) begin n_fail++; $display("FAIL stall_head_moved sync_err=%b exp=0", sync_err); end
  endtask

  task automatic test_sync_err();
    tick(20);
    n_checks++;
    if (sync_err !== 1'b0) begin n_fail++; $display("FAIL mismatch_pre got=%b exp=0", sync_err); end
    invalidate = 1'b1;
    {y_coord, x_coord} = 16'(exp_head + 1);
    tick(1);
    invalidate = 1'b0;
    exp_head = exp_head + 1;
    n_checks++;
    if (sync_err !== 1'b1) begin n_fail++; $display("FAIL mismatch_set got=%b exp=1", sync_err); end
    stream(20, "mismatch_hold");
    n_checks++;
    if (sync_err !== 1'b1) begin n_fail++; $display("FAIL mismatch_sticky got=%b exp=1", sync_err); end
  endtask

  task automatic test_resync_drain();
    int c0, p0, p1, c1, guard;
    tick(100);
    pop_allow = 0;
    c0 = cmd_log.size();
    stream(64, "pre_resync");
    guard = 0;
    while (cmd_log.size() == c0 && guard < 50) begin tick(1); guard++; end
    n_checks++;
    if (cmd_log.size() != c0 + 1) begin n_fail++; $display("FAIL resync_cmd_issue got=%0d exp=%0d", cmd_log.size(), c0 + 1); end
    p0 = pop_cnt;
    pop_allow = 6;
    guard = 0;
    while (pop_cnt < p0 + 6 && guard < 50) begin tick(1); guard++; end
    tick(3);
    n_checks++;
    if (pop_cnt != p0 + 6) begin n_fail++; $display("FAIL resync_prepop got=%0d exp=6", pop_cnt - p0); end
    do_resync(8'h12, 8'h05);
    pop_allow = -1;
    p1 = pop_cnt;
    c1 = cmd_log.size();
    n_checks += 2;
    if (sync_err !== 1'b0) begin n_fail++; $display("FAIL resync_clear got=%b exp=0", sync_err); end
    if (empty !== 1'b1) begin n_fail++; $display("FAIL resync_empty got=%b exp=1", empty); end
    guard = 0;
    while (cmd_log.size() == c1 && guard < 100) begin tick(1); guard++; end
    n_checks++;
    if (cmd_log.size() == c1) begin
      n_fail++;
      $display("FAIL resync_next_cmd timeout got=none exp=10510");
    end else begin
      n_checks++;
      if (pop_cnt - p1 != 10) begin n_fail++; $display("FAIL resync_drained got=%0d exp=10", pop_cnt - p1); end
      if (cmd_log[c1] !== 30'h10510) begin n_fail++; $display("FAIL resync_addr got=%h exp=10510", cmd_log[c1]); end
    end
    exp_head = 16'h0510;
    stream(64, "post_resync");
  endtask

  task automatic test_frame_switch();
    int c0;
    logic [29:0] exp_addr [6];
    exp_addr = '{30'h1BF00, 30'h1BF40, 30'h1BF80, 30'h1BFC0, 30'h20000, 30'h20040};
    frame_sel = 1'b1;
    do_resync(8'h00, 8'd191);
    c0 = cmd_log.size();
    exp_head = 16'hBF00;
    stream(512, "frame_switch");
    n_checks++;
    if (cmd_log.size() < c0 + 6) begin
      n_fail++;
      $display("FAIL switch_cmd_count got=%0d exp>=%0d", cmd_log.size() - c0, 6);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (cmd_log[c0 + i] !== exp_addr[i]) begin
          n_fail++;
          $display("FAIL switch_addr%0d got=%h exp=%h", i, cmd_log[c0 + i], exp_addr[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_initial_fill();
    test_full_frame();
    test_stall();
    test_sync_err();
    test_resync_drain();
    test_frame_switch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
